// File: rtl/booth16_pp_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : booth16_pp_gen_if
//  Description : Load and partial-product handshake bundle for booth16_pp_gen.
//                master modport = producer of operands / consumer of pps
//                slave  modport = the partial-product generator itself
//                Signals:
//                  start_i    load request (accepted only when idle)
//                  a_i, b_i   signed multiplicand / multiplier, N bits
//                  busy_o     operation in progress
//                  pp_o       signed partial product, PPW bits
//                  pp_valid_o pp_o valid
//                  pp_ready_i downstream accepts pp_o
//                  pp_last_o  marks the final digit's partial product
//                  digit_o    signed recoded digit (BOOTH16_DIGIT_DBG_EN only)
//  Revision    : 1.0  initial release
// ============================================================================
interface booth16_pp_gen_if #(
    parameter int WIDTH = 16
);
    localparam int N   = WIDTH / 2;
    localparam int PPW = N + 4;

    logic           start_i;
    logic [N-1:0]   a_i;
    logic [N-1:0]   b_i;
    logic           busy_o;
    logic [PPW-1:0] pp_o;
    logic           pp_valid_o;
    logic           pp_ready_i;
    logic           pp_last_o;
`ifdef BOOTH16_DIGIT_DBG_EN
    logic [4:0]     digit_o;

    modport master (
        output start_i, a_i, b_i, pp_ready_i,
        input  busy_o, pp_o, pp_valid_o, pp_last_o, digit_o
    );
    modport slave (
        input  start_i, a_i, b_i, pp_ready_i,
        output busy_o, pp_o, pp_valid_o, pp_last_o, digit_o
    );
`else
    modport master (
        output start_i, a_i, b_i, pp_ready_i,
        input  busy_o, pp_o, pp_valid_o, pp_last_o
    );
    modport slave (
        input  start_i, a_i, b_i, pp_ready_i,
        output busy_o, pp_o, pp_valid_o, pp_last_o
    );
`endif
endinterface
`default_nettype wire

// File: rtl/booth16_pp_gen.sv
`default_nettype none
// ============================================================================
//  Module      : booth16_pp_gen
//  Description : Radix-16 Booth partial-product generator. Captures signed
//                A and B, precomputes 3A/5A/7A, recodes B into N/4 signed
//                digits in [-8,+8] (LSB digit first) and emits digit*A per
//                handshake to the downstream accumulate/shift stage.
//  Ports       : clk   clock, all state on rising edge
//                rst   synchronous active-high reset
//                pp_if booth16_pp_gen_if.slave (load + pp handshake)
//  Parameters  : WIDTH product width; operands are N = WIDTH/2 bits
//  Options     : BOOTH16_DIGIT_DBG_EN adds a registered digit_o output
//  Revision    : 1.0  initial release
// ============================================================================
module booth16_pp_gen #(
    parameter int WIDTH = 16
) (
    input  wire logic           clk,
    input  wire logic           rst,
    booth16_pp_gen_if.slave     pp_if
);
    localparam int N   = WIDTH / 2;
    localparam int ND  = N / 4;
    localparam int PPW = N + 4;
    localparam int CW  = (ND > 1) ? $clog2(ND) : 1;

    localparam logic [CW-1:0] c_LAST_K = CW'(ND - 1);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_PRECOMP = 2'd1;
    localparam logic [1:0] c_ST_EMIT    = 2'd2;

    if ((WIDTH % 8 != 0) || (WIDTH < 8)) begin : g_width_check
        $fatal(1, "booth16_pp_gen: WIDTH must be a multiple of 8 and >= 8");
    end

    logic [1:0]     r_state;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic [PPW-1:0] r_m3;
    logic [PPW-1:0] r_m5;
    logic [PPW-1:0] r_m7;
    logic [CW-1:0]  r_k;
    logic [PPW-1:0] r_pp;
    logic           r_valid;
    logic           r_last;
    logic           r_busy;
`ifdef BOOTH16_DIGIT_DBG_EN
    logic [4:0]     r_digit;
`endif

    logic [PPW-1:0]    w_a_ext;
    logic [PPW-1:0]    w_m3_c;
    logic [PPW-1:0]    w_m5_c;
    logic [PPW-1:0]    w_m7_c;
    logic [PPW-1:0]    w_m3;
    logic [PPW-1:0]    w_m5;
    logic [PPW-1:0]    w_m7;
    logic [N:0]        w_b_ext;
    logic [CW-1:0]     w_idx;
    logic [CW+1:0]     w_base;
    logic [4:0]        w_win;
    logic signed [4:0] w_dig;
    logic [4:0]        w_mag;
    logic [PPW-1:0]    w_mult;
    logic [PPW-1:0]    w_pp_next;
    logic              w_is_last;
    logic              w_hs;

    // Odd multiples straight from the captured operand. During PRECOMP the
    // registers are not yet loaded, so the first pp uses these directly.
    assign w_a_ext = {{(PPW-N){r_a[N-1]}}, r_a};
    assign w_m3_c  = (w_a_ext << 1) + w_a_ext;
    assign w_m5_c  = (w_a_ext << 2) + w_a_ext;
    assign w_m7_c  = (w_a_ext << 3) - w_a_ext;

    assign w_m3 = (r_state == c_ST_PRECOMP) ? w_m3_c : r_m3;
    assign w_m5 = (r_state == c_ST_PRECOMP) ? w_m5_c : r_m5;
    assign w_m7 = (r_state == c_ST_PRECOMP) ? w_m7_c : r_m7;

    // Index of the digit being loaded into the output register: digit 0
    // from PRECOMP, the successor of the presented digit from EMIT.
    assign w_idx     = (r_state == c_ST_EMIT) ? (r_k + CW'(1)) : '0;
    assign w_is_last = (w_idx == c_LAST_K);
    assign w_hs      = r_valid & pp_if.pp_ready_i;

    // Five-bit window b[4k+3 : 4k-1]; the appended zero supplies b[-1].
    assign w_b_ext = {r_b, 1'b0};
    assign w_base  = {w_idx, 2'b00};
    assign w_win   = w_b_ext[w_base +: 5];

    // {w4,w4,w3,w2,w1} as signed = -8*w4 + 4*w3 + 2*w2 + w1; add w0.
    assign w_dig = $signed({w_win[4], w_win[4:1]}) + $signed({4'b0000, w_win[0]});
    assign w_mag = w_dig[4] ? (~w_dig + 5'd1) : w_dig;

    always_comb begin
        w_mult = '0;
        case (w_mag)
            5'd1:    w_mult = w_a_ext;
            5'd2:    w_mult = w_a_ext << 1;
            5'd3:    w_mult = w_m3;
            5'd4:    w_mult = w_a_ext << 2;
            5'd5:    w_mult = w_m5;
            5'd6:    w_mult = w_m3 << 1;
            5'd7:    w_mult = w_m7;
            5'd8:    w_mult = w_a_ext << 3;
            default: w_mult = '0;
        endcase
    end

    assign w_pp_next = w_dig[4] ? (~w_mult + PPW'(1)) : w_mult;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_m3    <= '0;
            r_m5    <= '0;
            r_m7    <= '0;
            r_k     <= '0;
            r_pp    <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
`ifdef BOOTH16_DIGIT_DBG_EN
            r_digit <= '0;
`endif
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (pp_if.start_i) begin
                        r_a     <= pp_if.a_i;
                        r_b     <= pp_if.b_i;
                        r_k     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_ST_PRECOMP;
                    end
                end
                c_ST_PRECOMP: begin
                    r_m3    <= w_m3_c;
                    r_m5    <= w_m5_c;
                    r_m7    <= w_m7_c;
                    r_pp    <= w_pp_next;
                    r_valid <= 1'b1;
                    r_last  <= w_is_last;
`ifdef BOOTH16_DIGIT_DBG_EN
                    r_digit <= w_dig;
`endif
                    r_state <= c_ST_EMIT;
                end
                c_ST_EMIT: begin
                    if (w_hs) begin
                        if (r_last) begin
                            // pp_o deliberately keeps its last value while idle.
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_k     <= w_idx;
                            r_pp    <= w_pp_next;
                            r_last  <= w_is_last;
`ifdef BOOTH16_DIGIT_DBG_EN
                            r_digit <= w_dig;
`endif
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign pp_if.busy_o     = r_busy;
    assign pp_if.pp_o       = r_pp;
    assign pp_if.pp_valid_o = r_valid;
    assign pp_if.pp_last_o  = r_last;
`ifdef BOOTH16_DIGIT_DBG_EN
    assign pp_if.digit_o    = r_digit;
`endif

endmodule
`default_nettype wire
